mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle signed multiply/divide responder for the control unit's mult/div requests.
//  The control unit pulses start with op and operands, waits on busy, and samples done.
//  Results land in the HI/LO registers that feed the MemToReg mux (mfhi/mflo).
//  The divide-by-zero indication feeds the DIV_ZERO_EXP exception path.
// PARAMETERS
//  WIDTH  32  operand width; hi and lo are each WIDTH bits; one iteration per bit
// PORTS
//  clk       in   1      system clock; all state changes on rising edge
//  reset     in   1      synchronous, active-high
//  start     in   1      request strobe; sampled only in IDLE
//  op        in   1      0 = mult (signed), 1 = div (signed); sampled with start
//  a         in   WIDTH  multiplicand / dividend (RegA_out); sampled with start
//  b         in   WIDTH  multiplier / divisor (RegB_out); sampled with start
//  busy      out  1      high from the cycle after start is accepted until done
//  done      out  1      one-cycle completion pulse
//  div_zero  out  1      one-cycle pulse, coincident with done, for div with b==0
//  hi        out  WIDTH  mult: product[2W-1:W]; div: remainder
//  lo        out  WIDTH  mult: product[W-1:0];  div: quotient
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0. Reset wins over every other input.
//  Reset mid-operation aborts the operation. No done is produced for it.
//  FSM states are IDLE, MULT, DIV, FINISH.
//   IDLE: when start=1, latch a, b and op, and clear the iteration counter.
//    If op=1 and b==0, go to FINISH with dz flag set.
//    Otherwise go to MULT or DIV.
//   MULT: radix-2 Booth on a 2W+1-bit accumulator. One step per cycle for WIDTH cycles, then FINISH.
//   DIV: restoring division on |a| and |b|. One quotient bit per cycle for WIDTH cycles, then FINISH.
//   FINISH: write hi/lo (except on dz), pulse done (plus div_zero if dz), return to IDLE.
//  busy is 1 in the MULT, DIV and FINISH states, and 0 in IDLE.
//  done and div_zero are registered and high for exactly one cycle.
//  Latency, with start sampled at edge 0:
//   mult/div: done high after edge WIDTH+1 (33 cycles for WIDTH=32).
//   div by zero: done high after edge 1.
//  Result registers:
//   hi/lo change only in the done cycle, and hold until the next completed operation.
//   On divide-by-zero, hi and lo keep their previous values.
//  Arithmetic rules:
//   Mult: full signed 2W-bit product, never overflows.
//   Div quotient: negated when sign(a) != sign(b). Truncates toward zero.
//   Div remainder: takes the sign of a, so a == q*b + r.
//   Div -2^(W-1) / -1: wraps to lo=0x80000000, hi=0. No flag is raised.
//  Handshake: start is ignored while busy=1. A start in the same cycle as done is ignored.
//   The earliest next start is the cycle after done.
//  Operands are latched; a, b and op may change freely while busy.
// TESTING
//  1. mult a=7, b=0xFFFFFFFD (-3) -> done after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2. mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; busy high for cycles 1..33.
//  3. div a=100, b=0xFFFFFFF9 (-7) -> lo=0xFFFFFFF2 (-14), hi=0x00000002.
//  4. div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     Also div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5. Preload hi=1, lo=2, then div a=5, b=0 -> done and div_zero pulse after edge 1.
//     hi=1 and lo=2 are unchanged; busy is high for exactly one cycle.
//  6. Start a mult, then re-assert start with new operands at cycle 5 -> ignored, original result.
//     Start a mult, then assert reset at cycle 10 -> busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// Results land in hi/lo on the done pulse; divide by zero leaves hi/lo untouched.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       state_dbg
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_hi;   // Booth A / division partial remainder
   logic [WIDTH-1:0] acc_lo;   // Booth Q / dividend shifting into quotient
   logic             acc_q1;
   logic [WIDTH-1:0] mcand;    // multiplicand or |divisor|
   logic             op_r, dz_r, neg_q, neg_r;
   logic             last_step, accept;
   logic [WIDTH:0]   booth_sum, div_shift, div_diff;

   assign last_step = (cnt == CW'(WIDTH - 1));
   // A start landing in the done cycle must not launch a new operation.
   assign accept    = (state == IDLE) && start && !done;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (accept) begin
                    if (op && (b == '0)) state_nxt = FINISH;
                    else if (op)         state_nxt = DIV;
                    else                 state_nxt = MULT;
                 end
         MULT:   if (last_step) state_nxt = FINISH;
         DIV:    if (last_step) state_nxt = FINISH;
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Booth add/sub done one bit wider so the arithmetic shift sees the true sign.
   always_comb begin
      booth_sum = {acc_hi[WIDTH-1], acc_hi};
      case ({acc_lo[0], acc_q1})
         2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {mcand[WIDTH-1], mcand};
         2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {mcand[WIDTH-1], mcand};
         default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
      endcase
   end

   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mcand};

   always_ff @(posedge clk) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         acc_q1   <= 1'b0;
         mcand    <= '0;
         op_r     <= 1'b0;
         dz_r     <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               cnt    <= '0;
               acc_hi <= '0;
               acc_q1 <= 1'b0;
               op_r   <= op;
               dz_r   <= op && (b == '0);
               neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
               neg_r  <= a[WIDTH-1];
               if (op) begin
                  acc_lo <= a[WIDTH-1] ? -a : a;
                  mcand  <= b[WIDTH-1] ? -b : b;
               end else begin
                  acc_lo <= b;
                  mcand  <= a;
               end
            end
            MULT: begin
               acc_hi <= booth_sum[WIDTH:1];
               acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
               acc_q1 <= acc_lo[0];
               cnt    <= cnt + CW'(1);
            end
            DIV: begin
               acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
               cnt    <= cnt + CW'(1);
            end
            FINISH: begin
               done     <= 1'b1;
               div_zero <= dz_r;
               if (!dz_r) begin
                  if (op_r) begin
                     lo <= neg_q ? -acc_lo : acc_lo;
                     hi <= neg_r ? -acc_hi : acc_hi;
                  end else begin
                     hi <= acc_hi;
                     lo <= acc_lo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations checked against a plain signed-arithmetic reference model.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, op;
   logic [W-1:0] a, b;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;
   logic [1:0]   state_dbg;

   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   cur_hi, cur_lo;
   int             n_checks = 0;
   int             n_pass   = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: whole-number signed arithmetic, truncating division.
   task automatic model(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic dz, output logic [W-1:0] eh, output logic [W-1:0] el);
      longint sa, sb, p, q, r;
      sa = $signed(ia);
      sb = $signed(ib);
      dz = 1'b0;
      eh = cur_hi;
      el = cur_lo;
      if (!o) begin
         p  = sa * sb;
         eh = p[63:32];
         el = p[31:0];
      end else if (sb == 0) begin
         dz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         el = q[31:0];
         eh = r[31:0];
      end
   endtask

   task automatic run_op(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib);
      logic         dz, got;
      logic [W-1:0] eh, el;
      int           n, nbusy;
      model(o, ia, ib, dz, eh, el);
      exp_q.push_back({eh, el});
      @(negedge clk);
      start = 1'b1; op = o; a = ia; b = ib;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
      n = 0; nbusy = 0; got = 1'b0;
      while (n < 100) begin
         if (busy) nbusy++;
         if (n == 5) begin
            start = 1'b1; a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
      check("done_seen", 64'(got), 64'd1);
      check("latency", 64'(n), dz ? 64'd1 : 64'd33);
      check("busy_cycles", 64'(nbusy), dz ? 64'd1 : 64'd33);
      check("busy_at_done", 64'(busy), 64'd0);
      check("div_zero", 64'(div_zero), 64'(dz));
      check("hi_lo", {hi, lo}, exp_q.pop_front());
      // start asserted in the done cycle must be ignored
      start = 1'b1; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_one_cycle", 64'(done), 64'd0);
      check("start_in_done_ignored", 64'(busy), 64'd0);
      cur_hi = hi;
      cur_lo = lo;
      if (!dz) begin
         cur_hi = eh;
         cur_lo = el;
      end
   endtask

   task automatic reset_mid_op();
      int ndone;
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hi_lo", {hi, lo}, 64'd0);
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("rst_no_done", 64'(ndone), 64'd0);
      cur_hi = '0;
      cur_lo = '0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      cur_hi = '0; cur_lo = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_div_zero", 64'(div_zero), 64'd0);
      check("reset_hi_lo", {hi, lo}, 64'd0);
      reset = 1'b0;

      run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
      run_op(1'b1, 32'd100, 32'hFFFF_FFF9);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 32'd7, 32'd3);              // preload hi=1, lo=2
      check("preload", {cur_hi, cur_lo}, {32'd1, 32'd2});
      run_op(1'b1, 32'd5, 32'd0);
      run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      run_op(1'b1, 32'd0, 32'h8000_0000);
      reset_mid_op();

      for (int i = 0; i < 40; i++) begin
         logic         ro;
         logic [W-1:0] ra, rb;
         ro = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = W'($urandom_range(1, 9));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op(ro, ra, rb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
